conv_pass_scheduler: RTL

CONV_PASS_SCHEDULER -- requirements
Module: conv_pass_scheduler

---
 rtl/conv_pass_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/conv_pass_scheduler.sv
// conv_pass_scheduler
//
// Sequences a multi-pass convolution job over a ping-pong pair of frame
// buffers. Each pass resets the engine for a fixed number of cycles, lets it
// run over one frame, checks that exactly one frame of pixels was read and
// written, then swaps buffers and moves on to the next filter.
//
// Optional feature: define CONV_SCHED_MAXPOOL_EN to drive eng_max_en high
// during ENG_RST and RUN of the final pass. Otherwise eng_max_en is tied low.
//
// Ports:
//   clk               single clock, rising edge
//   reset             synchronous, active-low reset
//   start             one-cycle pulse, starts a job from IDLE
//   abort             level, forces ERROR from any non-IDLE state
//   num_passes        passes per job minus 1
//   filter_seq        filter select per pass, pass k uses bits [2k+1:2k]
//   eng_finished      engine end-of-frame flag
//   eng_read_request  engine consumed an input pixel this cycle
//   eng_write_request engine produced an output pixel this cycle
//   eng_reset         active-high engine reset
//   eng_sw            engine filter select
//   eng_max_en        engine max-pool enable
//   src_buf           buffer the engine reads
//   dst_buf           buffer the engine writes (always ~src_buf)
//   pass_idx          current pass number
//   busy              job in progress
//   done              one-cycle pulse on successful job end
//   error             sticky job failure flag
module conv_pass_scheduler #(
  parameter int unsigned FRAME_PIXELS   = 307200,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter int unsigned ENG_RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] num_passes,
  input  logic [7:0] filter_seq,
  input  logic       eng_finished,
  input  logic       eng_read_request,
  input  logic       eng_write_request,
  output logic       eng_reset,
  output logic [1:0] eng_sw,
  output logic       eng_max_en,
  output logic       src_buf,
  output logic       dst_buf,
  output logic [1:0] pass_idx,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [31:0] RST_LAST     = 32'(ENG_RST_CYCLES - 1);
  localparam logic [31:0] FRAME_COUNT  = 32'(FRAME_PIXELS);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    RUN,
    CHECK,
    SWAP,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  passes_q;
  logic [7:0]  filters_q;
  logic [31:0] rst_cnt;
  logic [31:0] run_cnt;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [1:0]  pass_q;
  logic [1:0]  pass_inc;
  logic        src_q;
  logic        error_q;
  logic [1:0]  sw_q;

  assign pass_inc = pass_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Abort overrides every other transition once a job has been accepted.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    eng_reset  = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) state_next = ENG_RST;
      end
      ENG_RST: begin
        busy = 1'b1;
        if (rst_cnt == RST_LAST) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        eng_reset = 1'b0;
        if (eng_finished)                state_next = CHECK;
        else if (run_cnt == TIMEOUT_LAST) state_next = ERROR;
      end
      CHECK: begin
        busy      = 1'b1;
        eng_reset = 1'b0;
        if (rd_cnt == FRAME_COUNT && wr_cnt == FRAME_COUNT) state_next = SWAP;
        else                                                state_next = ERROR;
      end
      SWAP: begin
        busy      = 1'b1;
        eng_reset = 1'b0;
        if (pass_q == passes_q) state_next = DONE;
        else                    state_next = ENG_RST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = ERROR;
  end

  // Job context, pass bookkeeping and the per-pass pixel/cycle counters.
  // eng_sw and the buffer select are only ever updated on the IDLE->ENG_RST
  // and SWAP->ENG_RST edges, so they stay stable while the engine runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      passes_q  <= 2'd0;
      filters_q <= 8'd0;
      rst_cnt   <= 32'd0;
      run_cnt   <= 32'd0;
      rd_cnt    <= 32'd0;
      wr_cnt    <= 32'd0;
      pass_q    <= 2'd0;
      src_q     <= 1'b0;
      error_q   <= 1'b0;
      sw_q      <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            passes_q  <= num_passes;
            filters_q <= filter_seq;
            pass_q    <= 2'd0;
            src_q     <= 1'b0;
            error_q   <= 1'b0;
            sw_q      <= filter_seq[1:0];
            rst_cnt   <= 32'd0;
          end
        end
        ENG_RST: begin
          rst_cnt <= rst_cnt + 32'd1;
          run_cnt <= 32'd0;
          rd_cnt  <= 32'd0;
          wr_cnt  <= 32'd0;
        end
        RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (eng_read_request && rd_cnt != 32'hFFFF_FFFF)  rd_cnt <= rd_cnt + 32'd1;
          if (eng_write_request && wr_cnt != 32'hFFFF_FFFF) wr_cnt <= wr_cnt + 32'd1;
        end
        SWAP: begin
          if (pass_q != passes_q && !abort) begin
            pass_q  <= pass_inc;
            src_q   <= ~src_q;
            sw_q    <= filters_q[{pass_inc, 1'b0} +: 2];
            rst_cnt <= 32'd0;
          end
        end
        default: ;
      endcase
      if (state_next == ERROR) error_q <= 1'b1;
    end
  end

  assign eng_sw   = sw_q;
  assign src_buf  = src_q;
  assign dst_buf  = ~src_q;
  assign pass_idx = pass_q;
  assign error    = error_q;

`ifdef CONV_SCHED_MAXPOOL_EN
  assign eng_max_en = (state == ENG_RST || state == RUN) && (pass_q == passes_q);
`else
  assign eng_max_en = 1'b0;
`endif

endmodule
